// File: rtl/r2r_dac_wavegen.sv
`timescale 1ns/1ps
// Divider-clocked phase accumulator producing saw/triangle/square/external samples
// for an N-bit R2R ladder, with binary-shift amplitude and a small register write port.
module r2r_dac_wavegen #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DIV_W  = 12,
  localparam int unsigned DATA_W = (WIDTH > DIV_W) ? WIDTH : DIV_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [WIDTH-1:0]  ext_data,
  output logic              cnt_zero,
  output logic [WIDTH-1:0]  r2r_out
);

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_EXT    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ADDR_CTRL = 2'd0,
    ADDR_DIV  = 2'd1,
    ADDR_DUTY = 2'd2,
    ADDR_RSVD = 2'd3
  } addr_e;

  mode_e              mode_q, mode_d;
  logic               run_q, run_d;
  logic [2:0]         amp_q, amp_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   duty_q, duty_d;
  logic [WIDTH-1:0]   ph_q, ph_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               cnt_zero_q, cnt_zero_d;
  logic [WIDTH-1:0]   r2r_q, r2r_d;
  logic               phase_clr;
  logic [WIDTH-1:0]   wave;

  always_comb begin
    mode_d     = mode_q;
    run_d      = run_q;
    amp_d      = amp_q;
    div_d      = div_q;
    duty_d     = duty_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    cnt_zero_d = 1'b0;
    phase_clr  = 1'b0;

    if (wr_en) begin
      case (addr_e'(wr_addr))
        ADDR_CTRL: begin
          mode_d    = mode_e'(wr_data[1:0]);
          run_d     = wr_data[2];
          amp_d     = wr_data[5:3];
          phase_clr = wr_data[6];
        end
        ADDR_DIV:  div_d  = wr_data[DIV_W-1:0];
        ADDR_DUTY: duty_d = wr_data[WIDTH-1:0];
        default: ;
      endcase
    end

    // Tick decisions use the pre-write register values; a DIV write only
    // affects the reload at the next tick, so the running period completes.
    if (phase_clr) begin
      ph_d  = '0;
      cnt_d = '0;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        cnt_d      = div_q;
        ph_d       = ph_q + WIDTH'(1);
        cnt_zero_d = 1'b1;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end

    case (mode_q)
      MODE_SAW:    wave = ph_q;
      MODE_TRI:    wave = ph_q[WIDTH-1] ? ~{ph_q[WIDTH-2:0], 1'b0}
                                        :  {ph_q[WIDTH-2:0], 1'b0};
      MODE_SQUARE: wave = (ph_q < duty_q) ? '1 : '0;
      default:     wave = ext_data;
    endcase

    r2r_d = wave >> amp_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q     <= MODE_SAW;
      run_q      <= 1'b0;
      amp_q      <= '0;
      div_q      <= '0;
      duty_q     <= {1'b1, {(WIDTH-1){1'b0}}};
      ph_q       <= '0;
      cnt_q      <= '0;
      cnt_zero_q <= 1'b0;
      r2r_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      run_q      <= run_d;
      amp_q      <= amp_d;
      div_q      <= div_d;
      duty_q     <= duty_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      cnt_zero_q <= cnt_zero_d;
      r2r_q      <= r2r_d;
    end
  end

  assign cnt_zero = cnt_zero_q;
  assign r2r_out  = r2r_q;

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
`timescale 1ns/1ps
// Scoreboard bench for r2r_dac_wavegen: stimulus pushes hand-derived expected
// outputs after each edge; a monitor pops and compares on the falling edge.
module tb_r2r_dac_wavegen;

  logic        clk;
  logic        n_rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  ext_data;
  logic        cnt_zero;
  logic [7:0]  r2r_out;

  typedef struct {
    logic [7:0] r2r;
    logic       cz;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  r2r_dac_wavegen #(.WIDTH(8), .DIV_W(12)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ext_data (ext_data),
    .cnt_zero (cnt_zero),
    .r2r_out  (r2r_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  // Monitor: at most one expectation is pushed per cycle, after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (r2r_out !== e.r2r || cnt_zero !== e.cz) begin
          n_fail++;
          $display("FAIL %s: got r2r_out=%0d cnt_zero=%0b, expected r2r_out=%0d cnt_zero=%0b",
                   e.name, r2r_out, cnt_zero, e.r2r, e.cz);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_set(input logic [1:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [11:0] d);
    wr_set(a, d);
    tick();
  endtask

  task automatic chk(input logic [7:0] r, input logic c, input string n);
    exp_t e;
    e.r2r  = r;
    e.cz   = c;
    e.name = n;
    sb.push_back(e);
  endtask

  // Triangle for WIDTH=8: 0,2,..,254 then 255,253,..,1
  function automatic logic [7:0] tri_exp(input int k);
    int m;
    m = k % 256;
    return (m < 128) ? 8'(2 * m) : 8'(511 - 2 * m);
  endfunction

  logic [7:0] div_r[18] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2,
                            8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5, 8'd5, 8'd6};
  logic       div_cz[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    n_rst    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ext_data = '0;

    tick(); chk(8'd0, 1'b0, "reset");
    tick(); n_rst = 1'b1;

    // Sawtooth, DIV=0: phase advances every clock, wraps 255 -> 0
    wr(2'd1, 12'd0);
    wr_set(2'd0, 12'h004); tick(); chk(8'd0, 1'b0, "saw_start");
    for (int k = 1; k <= 258; k++) begin
      tick(); chk(8'(k - 1), 1'b1, "saw");
    end

    // DIV=3 then DIV=1 written mid-period; clear lands where cnt==0
    wr(2'd1, 12'd3);
    wr_set(2'd0, 12'h044); tick(); chk(8'd3, 1'b0, "clr_on_zero");
    for (int j = 0; j < 18; j++) begin
      if (j == 9) wr_set(2'd1, 12'd1);
      tick(); chk(div_r[j], div_cz[j], "div_period");
    end

    // Triangle, full period, then amplitude shift 2
    wr(2'd1, 12'd0);
    wr(2'd0, 12'h045);
    for (int k = 0; k <= 256; k++) begin
      tick(); chk(tri_exp(k), 1'b1, "tri");
    end
    wr(2'd0, 12'h055);
    for (int k = 0; k <= 130; k++) begin
      tick(); chk(tri_exp(k) >> 2, 1'b1, "tri_amp2");
    end

    // Square with DUTY=64, then DUTY=0, then DUTY=255
    wr(2'd2, 12'd64);
    wr(2'd0, 12'h046);
    for (int k = 0; k <= 257; k++) begin
      tick(); chk(((k % 256) < 64) ? 8'd255 : 8'd0, 1'b1, "sq_duty64");
    end
    wr(2'd2, 12'd0);
    for (int k = 0; k < 20; k++) begin
      tick(); chk(8'd0, 1'b1, "sq_duty0");
    end
    wr(2'd2, 12'd255);
    wr(2'd0, 12'h046);
    for (int k = 0; k <= 256; k++) begin
      tick(); chk(((k % 256) == 255) ? 8'd0 : 8'd255, 1'b1, "sq_duty255");
    end

    // External pass-through, amplitude shift, run stopped, reserved address
    ext_data = 8'hA5;
    wr(2'd0, 12'h007);
    for (int k = 0; k < 3; k++) begin
      tick(); chk(8'hA5, 1'b1, "ext");
    end
    wr(2'd0, 12'h027);
    for (int k = 0; k < 3; k++) begin
      tick(); chk(8'h0A, 1'b1, "ext_amp4");
    end
    wr(2'd0, 12'h023);
    for (int k = 0; k < 3; k++) begin
      tick(); chk(8'h0A, 1'b0, "ext_stopped");
    end
    ext_data = 8'h3C;
    tick(); chk(8'h03, 1'b0, "ext_track");
    wr_set(2'd3, 12'hFFF); tick(); chk(8'h03, 1'b0, "rsvd_write");
    tick(); chk(8'h03, 1'b0, "rsvd_ignored");

    // Asynchronous reset mid-run
    wr(2'd0, 12'h044);
    tick();
    tick(); chk(8'd1, 1'b1, "pre_rst_a");
    tick(); chk(8'd2, 1'b1, "pre_rst_b");
    tick(); n_rst = 1'b0; chk(8'd0, 1'b0, "async_rst");
    @(negedge clk); #1; n_rst = 1'b1;
    wr_set(2'd0, 12'h004); tick(); chk(8'd0, 1'b0, "post_rst_0");
    tick(); chk(8'd0, 1'b1, "post_rst_1");
    tick(); chk(8'd1, 1'b1, "post_rst_2");

    tick();
    tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
